// File: rtl/fft4_pkg.sv
// Shared types and complex-arithmetic helpers for the 4-point FFT datapath.
// All arithmetic wraps at the 16-bit component width.
package fft4_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STAGE1 = 2'd1,
        ST_STAGE2 = 2'd2,
        ST_DONE   = 2'd3
    } fft_state_e;

    localparam complex_t C_ZERO = '{re: 16'sd0, im: 16'sd0};

    function automatic complex_t c_add(input complex_t p, input complex_t q);
        complex_t r;
        r.re = p.re + q.re;
        r.im = p.im + q.im;
        return r;
    endfunction

    function automatic complex_t c_sub(input complex_t p, input complex_t q);
        complex_t r;
        r.re = p.re - q.re;
        r.im = p.im - q.im;
        return r;
    endfunction

    // Multiply by -j: (re + j*im) * -j = im - j*re
    function automatic complex_t c_mul_negj(input complex_t p);
        complex_t r;
        r.re = p.im;
        r.im = -p.re;
        return r;
    endfunction

endpackage

// File: rtl/fft_butterfly2.sv
// Combinational radix-2 butterfly: produces p+q and p-q with wrapping arithmetic.
module fft_butterfly2
    import fft4_pkg::*;
(
    input  complex_t p,
    input  complex_t q,
    output complex_t sum,
    output complex_t diff
);

    assign sum  = c_add(p, q);
    assign diff = c_sub(p, q);

endmodule

// File: rtl/fft_4point_32bit.sv
// 4-point radix-2 DIT FFT: capture, one registered butterfly stage, registered outputs.
// Results appear two edges after the capture edge, flagged by a one-cycle done pulse.
module fft_4point_32bit
    import fft4_pkg::*;
#(
    parameter int HALF_W = 16
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2*HALF_W-1:0]   in0,
    input  logic [2*HALF_W-1:0]   in1,
    input  logic [2*HALF_W-1:0]   in2,
    input  logic [2*HALF_W-1:0]   in3,
    output logic [2*HALF_W-1:0]   out0,
    output logic [2*HALF_W-1:0]   out1,
    output logic [2*HALF_W-1:0]   out2,
    output logic [2*HALF_W-1:0]   out3,
    output logic                  done
);

    fft_state_e state_r, next_state_s;
    complex_t   x0_r, x1_r, x2_r, x3_r;
    complex_t   a_r, b_r, c_r, d_r;
    complex_t   a_s, b_s, c_s, d_s;
    complex_t   x0_s, x1_s, x2_s, x3_s;
    complex_t   dj_s;
    complex_t   out0_r, out1_r, out2_r, out3_r;
    logic       done_r;

    fft_butterfly2 u_bf_s1_ev (.p(x0_r), .q(x2_r), .sum(a_s),  .diff(b_s));
    fft_butterfly2 u_bf_s1_od (.p(x1_r), .q(x3_r), .sum(c_s),  .diff(d_s));

    assign dj_s = c_mul_negj(d_r);

    fft_butterfly2 u_bf_s2_ev (.p(a_r),  .q(c_r),  .sum(x0_s), .diff(x2_s));
    fft_butterfly2 u_bf_s2_od (.p(b_r),  .q(dj_s), .sum(x1_s), .diff(x3_s));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; start only matters in IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_STAGE1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STAGE1: next_state_s = ST_STAGE2;
            ST_STAGE2: next_state_s = ST_DONE;
            ST_DONE:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Datapath registers: capture, stage-1 results, output bins and done flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0_r   <= C_ZERO;
            x1_r   <= C_ZERO;
            x2_r   <= C_ZERO;
            x3_r   <= C_ZERO;
            a_r    <= C_ZERO;
            b_r    <= C_ZERO;
            c_r    <= C_ZERO;
            d_r    <= C_ZERO;
            out0_r <= C_ZERO;
            out1_r <= C_ZERO;
            out2_r <= C_ZERO;
            out3_r <= C_ZERO;
            done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        x0_r <= in0;
                        x1_r <= in1;
                        x2_r <= in2;
                        x3_r <= in3;
                    end
                end
                ST_STAGE1: begin
                    a_r    <= a_s;
                    b_r    <= b_s;
                    c_r    <= c_s;
                    d_r    <= d_s;
                    done_r <= 1'b0;
                end
                ST_STAGE2: begin
                    out0_r <= x0_s;
                    out1_r <= x1_s;
                    out2_r <= x2_s;
                    out3_r <= x3_s;
                    done_r <= 1'b1;
                end
                ST_DONE: done_r <= 1'b0;
                default: done_r <= 1'b0;
            endcase
        end
    end

    assign out0 = out0_r;
    assign out1 = out1_r;
    assign out2 = out2_r;
    assign out3 = out3_r;
    assign done = done_r;

endmodule

// File: tb/tb_fft_4point_32bit.sv
// Scoreboard bench for fft_4point_32bit: expected bins come from a direct DFT model
// queued at each accepted start and compared when done pulses.
module tb_fft_4point_32bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] in0, in1, in2, in3;
    logic [31:0] out0, out1, out2, out3;
    logic        done;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e3;
        int          c0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    fft_4point_32bit #(.HALF_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int re, input int im);
        logic [15:0] r;
        logic [15:0] i;
        r = re[15:0];
        i = im[15:0];
        return {r, i};
    endfunction

    function automatic int sre(input logic [31:0] w);
        logic signed [15:0] t;
        t = w[31:16];
        return int'(t);
    endfunction

    function automatic int sim(input logic [31:0] w);
        logic signed [15:0] t;
        t = w[15:0];
        return int'(t);
    endfunction

    // Direct DFT with (-j)^(nk) expanded by hand
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c, input logic [31:0] d, input int c0);
        exp_t e;
        e.e0 = pk(sre(a) + sre(b) + sre(c) + sre(d), sim(a) + sim(b) + sim(c) + sim(d));
        e.e1 = pk(sre(a) + sim(b) - sre(c) - sim(d), sim(a) - sre(b) - sim(c) + sre(d));
        e.e2 = pk(sre(a) - sre(b) + sre(c) - sre(d), sim(a) - sim(b) + sim(c) - sim(d));
        e.e3 = pk(sre(a) - sim(b) - sre(c) + sim(d), sim(a) + sre(b) - sim(c) - sre(d));
        e.c0 = c0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check_val("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("x0", out0, e.e0);
                    check_val("x1", out1, e.e1);
                    check_val("x2", out2, e.e2);
                    check_val("x3", out3, e.e3);
                    check_val("latency", 32'(cyc - e.c0), 32'd3);
                end
            end
        end
    end

    // Drive a one-cycle start at a negedge and queue the expected result
    task automatic fire(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d, input bit expect_it);
        in0 = a; in1 = b; in2 = c; in3 = d;
        start = 1'b1;
        if (expect_it) sb.push_back(model(a, b, c, d, cyc));
        @(negedge clk);
        start = 1'b0;
        in0 = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
        check_val("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        reset = 1'b0;
        start = 1'b0;
        in0 = 32'd0; in1 = 32'd0; in2 = 32'd0; in3 = 32'd0;
        #12;
        check_val("rst_out0", out0, 32'd0);
        check_val("rst_out3", out3, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Ramp, with literal cross-check of the documented bins
        fire(pk(100, 0), pk(200, 0), pk(300, 0), pk(400, 0), 1'b1);
        drain();
        check_val("ramp_out0", out0, {16'h03E8, 16'h0000});
        check_val("ramp_out1", out1, {16'hFF38, 16'h00C8});
        check_val("ramp_out2", out2, {16'hFF38, 16'h0000});
        check_val("ramp_out3", out3, {16'hFF38, 16'hFF38});

        // Impulse, imaginary sample, wrap
        fire(pk(1000, 0), 32'd0, 32'd0, 32'd0, 1'b1);
        drain();
        check_val("imp_out2", out2, {16'h03E8, 16'h0000});
        fire(32'd0, pk(0, 100), 32'd0, 32'd0, 1'b1);
        drain();
        check_val("imag_out1", out1, {16'h0064, 16'h0000});
        check_val("imag_out3", out3, {16'hFF9C, 16'h0000});
        fire(pk(16000, 0), pk(16000, 0), pk(16000, 0), pk(16000, 0), 1'b1);
        drain();
        check_val("wrap_out0", out0, {16'hFA00, 16'h0000});
        check_val("wrap_out1", out1, 32'd0);

        // Three starts spaced 6 clocks apart; a busy-time start during STAGE1
        d0 = done_cnt;
        for (int t = 0; t < 3; t++) begin
            fire($urandom, $urandom, $urandom, $urandom, 1'b1);
            if (t == 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
        end
        drain();
        check_val("done_count", 32'(done_cnt - d0), 32'd3);

        // Random patterns
        for (int t = 0; t < 4; t++) begin
            fire($urandom, $urandom, $urandom, $urandom, 1'b1);
            drain();
        end

        // Held start: back-to-back transforms every 4 clocks
        d0 = done_cnt;
        in0 = pk(7, -3); in1 = pk(-9, 11); in2 = pk(5, 5); in3 = pk(-1, 2);
        start = 1'b1;
        sb.push_back(model(in0, in1, in2, in3, cyc));
        repeat (4) @(negedge clk);
        sb.push_back(model(in0, in1, in2, in3, cyc));
        @(negedge clk);
        start = 1'b0;
        drain();
        check_val("held_done_count", 32'(done_cnt - d0), 32'd2);

        // Reset during STAGE1 aborts the transform
        d0 = done_cnt;
        fire(pk(123, 456), pk(-7, 8), pk(9, -10), pk(11, 12), 1'b0);
        reset = 1'b0;
        #1;
        check_val("abort_out0", out0, 32'd0);
        check_val("abort_out1", out1, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
        fire(pk(100, 0), pk(200, 0), pk(300, 0), pk(400, 0), 1'b1);
        drain();

        check_val("sb_final", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
